// File: rtl/tri_raster_arbiter_if.sv
// tri_raster_arbiter_if: requester command bus, raster engine link and tagged pixel output
interface tri_raster_arbiter_if #(
   parameter int NREQ = 4,
   parameter int IDW = 2,
   parameter int CW = 32
);
   logic [NREQ-1:0] req_valid;
   logic [NREQ*6*CW-1:0] req_tri;
   logic [NREQ-1:0] req_ready;
   logic signed [CW-1:0] eng_x1, eng_y1, eng_x2, eng_y2, eng_x3, eng_y3;
   logic eng_restart;
   logic eng_finish;
   logic [9:0] eng_px;
   logic [8:0] eng_py;
   logic eng_pix_valid;
   logic [9:0] pix_x;
   logic [8:0] pix_y;
   logic pix_valid;
   logic [IDW-1:0] pix_id;
   logic done;
   logic [IDW-1:0] done_id;
   logic busy;
   logic wdog_err;
   modport slave (
      input req_valid, req_tri, eng_finish, eng_px, eng_py, eng_pix_valid,
      output req_ready, eng_x1, eng_y1, eng_x2, eng_y2, eng_x3, eng_y3, eng_restart,
      output pix_x, pix_y, pix_valid, pix_id, done, done_id, busy, wdog_err
   );
   modport master (
      output req_valid, req_tri, eng_finish, eng_px, eng_py, eng_pix_valid,
      input req_ready, eng_x1, eng_y1, eng_x2, eng_y2, eng_x3, eng_y3, eng_restart,
      input pix_x, pix_y, pix_valid, pix_id, done, done_id, busy, wdog_err
   );
endinterface

// File: rtl/tri_raster_arbiter.sv
// tri_raster_arbiter: round-robin sharing of one raster engine; TRI_ARB_WDOG_EN adds a RUN watchdog
module tri_raster_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW = 2,
   parameter int CW = 32,
   parameter int RESTART_CYC = 2,
   parameter int WDOG_CYC = 65536
) (
   input logic clk,
   input logic reset,
   tri_raster_arbiter_if.slave bus
);
`ifdef TRI_ARB_WDOG_EN
   localparam bit WDOG_EN = 1'b1;
`else
   localparam bit WDOG_EN = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, GRANT, LAUNCH, RUN, DONE} state_t;
   state_t state;
   logic [IDW-1:0] ptr, gnt, pick, idx;
   logic found, first, werr, fin_ok, wdog_hit;
   logic [31:0] cnt;
   logic [6*CW-1:0] sel;
   assign sel = bus.req_tri[int'(gnt)*6*CW +: 6*CW];
   assign fin_ok = !first && bus.eng_finish;
   assign wdog_hit = WDOG_EN && cnt == 32'(WDOG_CYC - 1);
   assign bus.busy = state != IDLE;
   assign bus.wdog_err = WDOG_EN & werr;
   // first valid requester above the pointer, wrapping; the last finisher ends up lowest priority
   always_comb begin
      pick = '0;
      found = 1'b0;
      idx = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            pick = idx;
            found = 1'b1;
         end
      end
   end
   // control FSM with registered handshake, engine and completion outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ptr <= IDW'(NREQ - 1);
         gnt <= '0;
         cnt <= '0;
         first <= 1'b0;
         werr <= 1'b0;
         bus.req_ready <= '0;
         {bus.eng_x1, bus.eng_y1, bus.eng_x2, bus.eng_y2, bus.eng_x3, bus.eng_y3} <= '0;
         bus.eng_restart <= 1'b1;
         bus.done <= 1'b0;
         bus.done_id <= '0;
      end else begin
         bus.req_ready <= '0;
         bus.done <= 1'b0;
         case (state)
            IDLE: if (found) begin
               gnt <= pick;
               bus.req_ready <= NREQ'(1) << pick;
               state <= GRANT;
            end
            GRANT: if (bus.req_valid[gnt]) begin
               bus.eng_x1 <= sel[0*CW +: CW];
               bus.eng_y1 <= sel[1*CW +: CW];
               bus.eng_x2 <= sel[2*CW +: CW];
               bus.eng_y2 <= sel[3*CW +: CW];
               bus.eng_x3 <= sel[4*CW +: CW];
               bus.eng_y3 <= sel[5*CW +: CW];
               cnt <= '0;
               state <= LAUNCH;
            end else begin
               state <= IDLE;
            end
            LAUNCH: if (cnt == 32'(RESTART_CYC - 1)) begin
               bus.eng_restart <= 1'b0;
               first <= 1'b1;
               cnt <= '0;
               state <= RUN;
            end else begin
               cnt <= cnt + 32'd1;
            end
            RUN: begin
               first <= 1'b0;
               if (WDOG_EN) cnt <= cnt + 32'd1;
               if (fin_ok || wdog_hit) begin
                  bus.done <= 1'b1;
                  bus.done_id <= gnt;
                  ptr <= gnt;
                  bus.eng_restart <= 1'b1;
                  if (!fin_ok) werr <= 1'b1;
                  state <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
   // pixel stream forwarded one cycle late, tagged with the owner, only while running
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.pix_valid <= 1'b0;
         bus.pix_x <= '0;
         bus.pix_y <= '0;
         bus.pix_id <= '0;
      end else begin
         bus.pix_valid <= (state == RUN) & bus.eng_pix_valid & ~bus.eng_finish;
         if ((state == RUN) & bus.eng_pix_valid & ~bus.eng_finish) begin
            bus.pix_x <= bus.eng_px;
            bus.pix_y <= bus.eng_py;
            bus.pix_id <= gnt;
         end
      end
   end
endmodule

// File: tb/tb_tri_raster_arbiter.sv
// tb_tri_raster_arbiter: random and directed stimulus checked against a timeline model of the arbiter
module tb_tri_raster_arbiter;
   localparam int NREQ = 4, IDW = 2, CW = 32, RC = 2, WD = 100;
`ifdef TRI_ARB_WDOG_EN
   localparam bit WDOG = 1'b1;
`else
   localparam bit WDOG = 1'b0;
`endif
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;
   tri_raster_arbiter_if #(.NREQ(NREQ), .IDW(IDW), .CW(CW)) bus();
   tri_raster_arbiter #(.NREQ(NREQ), .IDW(IDW), .CW(CW), .RESTART_CYC(RC), .WDOG_CYC(WD)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   int checks = 0, errors = 0;
   // model: mode 0 idle, 1 job in flight (timeline measured from grant edge t0), 2 done cycle
   int e = 0, mode = 0, t0 = 0, gid = 0, ptr_m = NREQ - 1;
   logic [NREQ-1:0] x_ready, prev;
   logic x_restart, x_pv, x_done, x_werr;
   logic [9:0] x_px;
   logic [8:0] x_py;
   logic [IDW-1:0] x_pid, x_did;
   logic signed [CW-1:0] x_v[6];
   int dlog[$];
   int rr_exp[6] = '{0, 1, 3, 0, 1, 3};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mode = 0; ptr_m = NREQ - 1; x_ready = '0; x_restart = 1'b1; x_pv = 1'b0; x_done = 1'b0;
      x_werr = 1'b0; x_px = '0; x_py = '0; x_pid = '0; x_did = '0;
      for (int f = 0; f < 6; f++) x_v[f] = '0;
   endtask

   task automatic model_step();
      int d, k, j;
      bit run, found, fin_ok;
      e++;
      d = e - 1 - t0;
      run = mode == 1 && d > RC;
      k = d - RC;
      x_ready = '0;
      x_done = 1'b0;
      x_pv = run && bus.eng_pix_valid && !bus.eng_finish;
      if (x_pv) begin
         x_px = bus.eng_px; x_py = bus.eng_py; x_pid = IDW'(gid);
      end
      if (mode == 2) mode = 0;
      else if (mode == 0) begin
         found = 0;
         for (int i = 1; i <= NREQ; i++) begin
            j = (ptr_m + i) % NREQ;
            if (!found && bus.req_valid[j]) begin
               found = 1; gid = j;
            end
         end
         if (found) begin
            mode = 1; t0 = e; x_ready[gid] = 1'b1;
         end
      end else if (d == 0) begin
         if (bus.req_valid[gid])
            for (int f = 0; f < 6; f++) x_v[f] = bus.req_tri[(gid*6+f)*CW +: CW];
         else mode = 0;
      end else if (run) begin
         fin_ok = k >= 2 && bus.eng_finish;
         if (fin_ok || (WDOG && k >= WD)) begin
            mode = 2; x_done = 1'b1; x_did = IDW'(gid); ptr_m = gid;
            if (!fin_ok) x_werr = 1'b1;
         end
      end
      x_restart = !(mode == 1 && e - t0 > RC);
   endtask

   task automatic compare();
      chk("req_ready", bus.req_ready, x_ready);
      chk("eng_restart", bus.eng_restart, x_restart);
      chk("busy", bus.busy, mode != 0);
      chk("done", bus.done, x_done);
      chk("done_id", bus.done_id, x_did);
      chk("pix_valid", bus.pix_valid, x_pv);
      chk("pix_x", bus.pix_x, x_px);
      chk("pix_y", bus.pix_y, x_py);
      chk("pix_id", bus.pix_id, x_pid);
      chk("wdog_err", bus.wdog_err, x_werr);
      chk("eng_x1", bus.eng_x1, x_v[0]);
      chk("eng_y1", bus.eng_y1, x_v[1]);
      chk("eng_x2", bus.eng_x2, x_v[2]);
      chk("eng_y2", bus.eng_y2, x_v[3]);
      chk("eng_x3", bus.eng_x3, x_v[4]);
      chk("eng_y3", bus.eng_y3, x_v[5]);
   endtask

   initial forever begin
      @(negedge clk);
      compare();
      if (bus.done === 1'b1) dlog.push_back(int'(bus.done_id));
   end

   task automatic tick();
      @(posedge clk);
      prev = x_ready;
      if (reset) model_step();
      #1;
   endtask

   task automatic rndtri(input int i);
      for (int f = 0; f < 6; f++) bus.req_tri[(i*6+f)*CW +: CW] = $urandom();
   endtask

   task automatic settri(input int i, input int a, input int b, input int c, input int d, input int g, input int h);
      int v[6];
      v = '{a, b, c, d, g, h};
      for (int f = 0; f < 6; f++) bus.req_tri[(i*6+f)*CW +: CW] = v[f];
   endtask

   task automatic run(input int n, input logic [NREQ-1:0] hold, input int arr, input int finp);
      for (int c = 0; c < n; c++) begin
         tick();
         for (int i = 0; i < NREQ; i++) begin
            if (prev[i]) begin
               if (!hold[i]) bus.req_valid[i] = 1'b0;
               rndtri(i);
            end else if (!bus.req_valid[i] && $urandom_range(0, 99) < arr) begin
               bus.req_valid[i] = 1'b1;
               rndtri(i);
            end
         end
         bus.eng_pix_valid = 1'($urandom_range(0, 1));
         bus.eng_px = 10'($urandom());
         bus.eng_py = 9'($urandom());
         bus.eng_finish = $urandom_range(0, 99) < finp;
      end
   endtask

   task automatic drain();
      for (int c = 0; c < 300 && (mode != 0 || bus.req_valid != '0); c++) run(1, '0, 0, 100);
      @(negedge clk);
      chk("drain_busy", bus.busy, 1'b0);
   endtask

   initial begin
      bus.req_valid = '0; bus.req_tri = '0; bus.eng_finish = 1'b0;
      bus.eng_px = '0; bus.eng_py = '0; bus.eng_pix_valid = 1'b0;
      model_reset();
      @(negedge clk);
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_restart", bus.eng_restart, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_pix_valid", bus.pix_valid, 0);
      chk("rst_wdog", bus.wdog_err, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      // single request from requester 0
      settri(0, 35, 40, 10, 20, 30, 60);
      bus.req_valid = 4'b0001;
      tick(); @(negedge clk);
      chk("t1_ready", bus.req_ready, 4'b0001);
      chk("t1_restart_grant", bus.eng_restart, 1);
      tick(); bus.req_valid = '0; @(negedge clk);
      chk("t1_ready_off", bus.req_ready, 0);
      chk("t1_restart_l1", bus.eng_restart, 1);
      chk("t1_x1", bus.eng_x1, 35); chk("t1_y1", bus.eng_y1, 40);
      chk("t1_x2", bus.eng_x2, 10); chk("t1_y2", bus.eng_y2, 20);
      chk("t1_x3", bus.eng_x3, 30); chk("t1_y3", bus.eng_y3, 60);
      tick(); @(negedge clk);
      chk("t1_restart_l2", bus.eng_restart, 1);
      tick(); bus.eng_finish = 1'b1; @(negedge clk);
      chk("t1_restart_run", bus.eng_restart, 0);
      tick(); @(negedge clk);
      chk("t1_fin_ignored", bus.done, 0);
      tick(); bus.eng_finish = 1'b0; @(negedge clk);
      chk("t1_done", bus.done, 1);
      chk("t1_done_id", bus.done_id, 0);
      tick(); @(negedge clk);
      chk("t1_idle", bus.busy, 0);
      // withdrawn request from requester 2
      bus.req_valid = 4'b0100;
      tick(); bus.req_valid = '0; @(negedge clk);
      chk("wd_ready", bus.req_ready, 4'b0100);
      tick(); @(negedge clk);
      chk("wd_idle", bus.busy, 0);
      tick();
      // pointer kept at 0, then pixel forwarding for requester 1
      settri(1, 1, 2, 3, 4, 5, 6); settri(3, 7, 8, 9, 10, 11, 12);
      bus.req_valid = 4'b1010; bus.eng_pix_valid = 1'b1; bus.eng_px = 10'd99; bus.eng_py = 9'd99;
      tick(); @(negedge clk);
      chk("ptr_kept", bus.req_ready, 4'b0010);
      chk("nopix_idle", bus.pix_valid, 0);
      tick(); bus.req_valid = 4'b1000; @(negedge clk);
      chk("nopix_grant", bus.pix_valid, 0);
      tick(); @(negedge clk);
      chk("nopix_l1", bus.pix_valid, 0);
      tick(); bus.eng_px = 10'd12; bus.eng_py = 9'd40; @(negedge clk);
      chk("nopix_l2", bus.pix_valid, 0);
      tick(); bus.eng_px = 10'd13; @(negedge clk);
      chk("pix0_v", bus.pix_valid, 1); chk("pix0_x", bus.pix_x, 12);
      chk("pix0_y", bus.pix_y, 40); chk("pix0_id", bus.pix_id, 1);
      tick(); bus.eng_px = 10'd14; @(negedge clk);
      chk("pix1_x", bus.pix_x, 13);
      tick(); bus.eng_pix_valid = 1'b0; bus.eng_finish = 1'b1; @(negedge clk);
      chk("pix2_x", bus.pix_x, 14);
      tick(); bus.eng_finish = 1'b0; @(negedge clk);
      chk("pix_end_v", bus.pix_valid, 0); chk("pix_hold_x", bus.pix_x, 14);
      chk("pix_done_id", bus.done_id, 1);
      drain();
      // round robin with 0, 1, 3 continuously requesting
      dlog.delete();
      bus.req_valid = 4'b1011; rndtri(0); rndtri(1); rndtri(3);
      for (int c = 0; c < 600 && dlog.size() < 6; c++) run(1, 4'b1011, 0, 30);
      bus.req_valid = '0;
      chk("rr_len", dlog.size() >= 6, 1);
      for (int i = 0; i < 6; i++) chk("rr_order", i < dlog.size() ? dlog[i] : -1, rr_exp[i]);
      drain();
      // randomized traffic
      run(3000, '0, 30, 25);
      bus.req_valid = '0;
      drain();
      // reset in the middle of RUN
      bus.req_valid = 4'b0001; rndtri(0);
      for (int c = 0; c < 50 && !(mode == 1 && !x_restart); c++) run(1, '0, 0, 0);
      run(3, '0, 0, 0);
      reset = 1'b0;
      model_reset();
      dlog.delete();
      bus.req_valid = '0;
      #1;
      chk("mid_rst_busy", bus.busy, 0); chk("mid_rst_restart", bus.eng_restart, 1);
      chk("mid_rst_x1", bus.eng_x1, 0); chk("mid_rst_pix_x", bus.pix_x, 0);
      chk("mid_rst_pix_id", bus.pix_id, 0); chk("mid_rst_done", bus.done, 0);
      tick();
      reset = 1'b1;
      bus.req_valid = 4'b0010; rndtri(1);
      for (int c = 0; c < 80 && dlog.size() < 1; c++) run(1, '0, 0, 50);
      chk("after_rst_cnt", dlog.size(), 1);
      chk("after_rst_id", dlog.size() > 0 ? dlog[0] : -1, 1);
      drain();
`ifdef TRI_ARB_WDOG_EN
      // engine that never finishes
      dlog.delete();
      bus.req_valid = 4'b0011; rndtri(0); rndtri(1);
      for (int c = 0; c < 400 && dlog.size() < 2; c++) run(1, '0, 0, 0);
      chk("wdog_jobs", dlog.size(), 2);
      chk("wdog_sticky", bus.wdog_err, 1);
      drain();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/tri_raster_arbiter.md
Name: tri_raster_arbiter

Overview:
- Round-robin scheduler that shares the single filled-triangle raster engine between NREQ independent triangle requesters.
- Accepts one triangle command per handshake and latches its six vertex coordinates.
- Sequences the engine through restart/run/finish, then forwards the engine's pixel stream tagged with the owning requester index.
- Sits between the command sources (sprite, UI, test pattern) and the raster engine / framebuffer writer.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester index width, clog2(NREQ).
- CW, 32, signed coordinate width.
- RESTART_CYC, 2, cycles eng_restart is held high in LAUNCH (>=1).
- WDOG_CYC, 65536, watchdog limit in RUN cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester command valid.
- req_tri  in  NREQ*6*CW  per-requester packed {x1,y1,x2,y2,x3,y3}; x1 in the LSBs; requester i occupies slice i.
- req_ready  out  NREQ  one-hot acceptance pulse.
- eng_x1..eng_y3  out  CW each  latched vertices driven to the engine.
- eng_restart  out  1  engine synchronous restart, active-high.
- eng_finish  in  1  engine done level.
- eng_px  in  10  engine pixel X.
- eng_py  in  9  engine pixel Y.
- eng_pix_valid  in  1  engine pixel strobe.
- pix_x  out  10  registered pixel X.
- pix_y  out  9  registered pixel Y.
- pix_valid  out  1  registered pixel strobe.
- pix_id  out  IDW  owner of the current pixel.
- done  out  1  one-cycle pulse when a triangle completes.
- done_id  out  IDW  requester that completed.
- busy  out  1  high in any state other than IDLE.
- wdog_err  out  1  sticky watchdog error (optional feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Outputs: req_ready=0, eng_x1..eng_y3=0, eng_restart=1, pix_x=0, pix_y=0, pix_valid=0, pix_id=0, done=0, done_id=0, busy=0, wdog_err=0.
- IDLE:
  - eng_restart=1.
  - If any req_valid is high, pick the first valid requester searching from pointer+1 upward with wrap, register it in gnt, go to GRANT.
- GRANT (1 cycle):
  - req_ready[gnt]=1 and eng_restart=1.
  - If req_valid[gnt] is still high, latch slice gnt of req_tri into eng_x1..eng_y3 and go to LAUNCH.
  - Otherwise (protocol violation) return to IDLE with no launch and no pointer update.
- LAUNCH:
  - eng_restart=1 for exactly RESTART_CYC cycles (counter), then go to RUN.
- RUN:
  - eng_restart=0; eng_x1..eng_y3 held stable.
  - eng_finish is ignored in the first RUN cycle.
  - After that, eng_finish=1 moves the block to DONE.
- DONE (1 cycle):
  - done=1, done_id=gnt, pointer=gnt, eng_restart=1, then go to IDLE.
  - Minimum spacing between consecutive grants: 1 (IDLE) + 1 (GRANT) + RESTART_CYC + RUN cycles + 1 (DONE).
- Requester protocol: once req_valid is asserted, the requester holds it and its slice of req_tri stable until it sees req_ready.
- Pixel path: registered, 1-cycle latency.
  - pix_valid <= (state==RUN) & eng_pix_valid & ~eng_finish.
  - pix_x, pix_y and pix_id (=gnt) update only when pix_valid is set; otherwise they hold.
  - No pixels are forwarded outside RUN.
- Simultaneous events:
  - New req_valid during RUN waits; it is arbitrated in the next IDLE.
  - req_valid from the requester that just finished is arbitrated last among those pending.
- Reset mid-operation: immediate return to IDLE and eng_restart=1. An in-flight triangle is dropped without a done pulse.
- Coordinates pass through unmodified. No clipping, sorting or arithmetic is done in this block.

Optional Feature:
- Macro: TRI_ARB_WDOG_EN.
- When defined:
  - A 32-bit counter counts RUN cycles.
  - When the count reaches WDOG_CYC without eng_finish, go to DONE with done=1, done_id=gnt, and set wdog_err=1.
  - wdog_err stays set until reset.
- When not defined:
  - No counter; RUN waits on eng_finish indefinitely.
  - wdog_err is tied to 0.

Test Plan:
- Single request:
  - Stimulus: requester 0, triangle (35,40),(10,20),(30,60).
  - Required: req_ready[0] pulses 1 cycle after req_valid; eng_restart is high for 2 cycles after GRANT; eng vertices match the input; done pulses with done_id=0 one cycle after eng_finish.
- Round-robin:
  - Stimulus: requesters 0, 1 and 3 all valid continuously.
  - Required grant order 0,1,3,0,1,3; requester 2 is never granted.
- Pixel forwarding:
  - Stimulus: engine model emits (12,40),(13,40),(14,40) with eng_pix_valid during RUN.
  - Required: pix_x/pix_y show the same values one cycle later with pix_id=gnt; no pix_valid during IDLE, GRANT or LAUNCH, even if eng_pix_valid is forced high there.
- Withdrawn request:
  - Stimulus: req_valid[2] pulsed for 1 cycle only.
  - Required: GRANT then IDLE; no LAUNCH, no done, pointer unchanged.
- Reset mid-RUN:
  - Stimulus: pull reset low for 1 cycle during RUN.
  - Required: all outputs return to their reset values asynchronously; done is never pulsed; the next request restarts cleanly.
- Watchdog (TRI_ARB_WDOG_EN, WDOG_CYC=100):
  - Stimulus: engine never finishes.
  - Required: done and wdog_err go high after 100 RUN cycles; the next requester is then granted.
